swd_memap_seq: RTL and testbench

- Sequencer that turns single 32-bit memory read/write requests into ADIv5 MEM-AP command sequences (DP SELECT, AP CSW, AP TAR, AP DRW).
- Drives the command/response FIFO interface of the SWD ADIv5 engine and sits between the AHB3-lite remote bridge front end and that engine.
- Caches SELECT, CSW size and TAR so redundant register writes are skipped.
- Keeps one SWD command outstanding at a time.

---
 rtl/swd_memap_seq.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_swd_memap_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swd_memap_seq.sv
// swd_memap_seq
//   Turns single 32-bit memory read/write requests into ADIv5 MEM-AP command
//   sequences (DP SELECT, AP CSW, AP TAR, AP DRW) for the SWD ADIv5 engine.
//   SELECT, CSW size and TAR are cached, so redundant writes are skipped.
//   Only one SWD command is outstanding at any time.
//
// Ports
//   clk_i, reset_i        core clock, synchronous active-high reset
//   ap_sel_i              MEM-AP number, sampled at request accept
//   invalidate_i          one-cycle pulse clearing all caches
//   req_*                 request channel (valid/ready, write, size, addr, wdata)
//   rsp_*                 response channel (valid/ready, rdata, stat)
//   cmd_wrdata_o/wren_o   command FIFO write port {DATA, ADDR[3:2], APnDP, RnW}
//   cmd_wrfull_i          command FIFO full
//   resp_rddata_i         response FIFO data {DATA, STAT}, valid the cycle after rden
//   resp_rden_o           response FIFO pop
//   resp_rdempty_i        response FIFO empty
module swd_memap_seq #(
    parameter logic [31:0] CSW_BASE = 32'h2300_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  ap_sel_i,
    input  logic        invalidate_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic [2:0]  rsp_stat_o,
    output logic [35:0] cmd_wrdata_o,
    output logic        cmd_wren_o,
    input  logic        cmd_wrfull_i,
    input  logic [34:0] resp_rddata_i,
    output logic        resp_rden_o,
    input  logic        resp_rdempty_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WAIT, S_POP, S_CHK, S_REPLY
    } state_e;

    typedef enum logic [1:0] {
        STEP_SEL = 2'd0, STEP_CSW = 2'd1, STEP_TAR = 2'd2, STEP_DRW = 2'd3
    } step_e;

    localparam logic [2:0] STAT_OK = 3'b100;

    state_e      state_q, state_d;
    step_e       step_q, step_d, next_step;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  ap_q, ap_d;

    logic [7:0]  sel_q, sel_d;
    logic        sel_v_q, sel_v_d;
    logic [1:0]  csw_q, csw_d;
    logic        csw_v_q, csw_v_d;
    logic [31:0] tar_q, tar_d;
    logic        tar_v_q, tar_v_d;

    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [2:0]  rsp_stat_q, rsp_stat_d;
    logic [35:0] cmd_wrdata_q, cmd_wrdata_d;
    logic        cmd_wren_q, cmd_wren_d;
    logic        resp_rden_q, resp_rden_d;

    logic        in_idle;
    logic        resp_ok;
    logic [1:0]  size_norm;
    logic        cur_wr;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [7:0]  cur_ap;
    logic [1:0]  start_idx;
    logic        sel_miss, csw_miss, tar_miss;

    // Encodes one command word {DATA, ADDR[3:2], APnDP, RnW} for a step.
    function automatic logic [35:0] build_cmd(input step_e step, input logic wr,
                                              input logic [1:0] size, input logic [31:0] addr,
                                              input logic [31:0] wdata, input logic [7:0] ap);
        logic [35:0] cmd;
        case (step)
            STEP_SEL: cmd = {ap, 24'h0, 2'b10, 1'b0, 1'b0};
            STEP_CSW: cmd = {CSW_BASE | {30'h0, size}, 2'b00, 1'b1, 1'b0};
            STEP_TAR: cmd = {addr, 2'b01, 1'b1, 1'b0};
            default:  cmd = {(wr ? wdata : 32'h0), 2'b11, 1'b1, ~wr};
        endcase
        return cmd;
    endfunction

    // Request fields come straight from the inputs while accepting in IDLE,
    // and from the latched copies once a sequence is underway.
    always_comb begin
        in_idle   = (state_q == S_IDLE);
        resp_ok   = (resp_rddata_i[2:0] == STAT_OK);
        size_norm = (req_size_i == 2'd3) ? 2'd2 : req_size_i;
        cur_wr    = in_idle ? req_write_i : wr_q;
        cur_size  = in_idle ? size_norm   : size_q;
        cur_addr  = in_idle ? req_addr_i  : addr_q;
        cur_wdata = in_idle ? req_wdata_i : wdata_q;
        cur_ap    = in_idle ? ap_sel_i    : ap_q;
        start_idx = in_idle ? 2'd0 : step_q + 2'd1;
    end

    // Cache update: a step's cache becomes valid only after an OK response to
    // its own write; any failure, or an invalidate pulse, clears everything.
    // Invalidate is applied last so it wins over a coincident update.
    always_comb begin
        sel_d   = sel_q;
        sel_v_d = sel_v_q;
        csw_d   = csw_q;
        csw_v_d = csw_v_q;
        tar_d   = tar_q;
        tar_v_d = tar_v_q;
        if (state_q == S_CHK) begin
            if (resp_ok) begin
                case (step_q)
                    STEP_SEL: begin sel_d = ap_q;   sel_v_d = 1'b1; end
                    STEP_CSW: begin csw_d = size_q; csw_v_d = 1'b1; end
                    STEP_TAR: begin tar_d = addr_q; tar_v_d = 1'b1; end
                    default:  ;
                endcase
            end else begin
                sel_v_d = 1'b0;
                csw_v_d = 1'b0;
                tar_v_d = 1'b0;
            end
        end
        if (invalidate_i) begin
            sel_v_d = 1'b0;
            csw_v_d = 1'b0;
            tar_v_d = 1'b0;
        end
    end

    // Step selection looks only at steps after the one just completed, using
    // the post-update cache, so an invalidate mid-sequence never restarts it.
    always_comb begin
        sel_miss = !sel_v_d || (sel_d != cur_ap);
        csw_miss = !csw_v_d || (csw_d != cur_size);
        tar_miss = !tar_v_d || (tar_d != cur_addr);
        if (start_idx <= 2'd0 && sel_miss) begin
            next_step = STEP_SEL;
        end else if (start_idx <= 2'd1 && csw_miss) begin
            next_step = STEP_CSW;
        end else if (start_idx <= 2'd2 && tar_miss) begin
            next_step = STEP_TAR;
        end else begin
            next_step = STEP_DRW;
        end
    end

    // Main sequencer. Entering a step loads the command word and, if the FIFO
    // has room, writes it immediately so a cached request reaches the FIFO the
    // cycle after accept; otherwise the command is parked in S_CMD.
    always_comb begin
        logic enter_step;
        enter_step   = 1'b0;
        state_d      = state_q;
        step_d       = step_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ap_d         = ap_q;
        req_ready_d  = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_stat_d   = rsp_stat_q;
        cmd_wrdata_d = cmd_wrdata_q;
        cmd_wren_d   = 1'b0;
        resp_rden_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    wr_d       = req_write_i;
                    size_d     = size_norm;
                    addr_d     = req_addr_i;
                    wdata_d    = req_wdata_i;
                    ap_d       = ap_sel_i;
                    enter_step = 1'b1;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_CMD: begin
                if (!cmd_wrfull_i) begin
                    cmd_wren_d = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!resp_rdempty_i) begin
                    resp_rden_d = 1'b1;
                    state_d     = S_POP;
                end
            end
            S_POP: begin
                state_d = S_CHK;
            end
            S_CHK: begin
                if (resp_ok && step_q != STEP_DRW) begin
                    enter_step = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_stat_d  = resp_rddata_i[2:0];
                    rsp_rdata_d = (resp_ok && !wr_q) ? resp_rddata_i[34:3] : 32'h0;
                    state_d     = S_REPLY;
                end
            end
            S_REPLY: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_step) begin
            step_d       = next_step;
            cmd_wrdata_d = build_cmd(next_step, cur_wr, cur_size, cur_addr, cur_wdata, cur_ap);
            if (!cmd_wrfull_i) begin
                cmd_wren_d = 1'b1;
                state_d    = S_WAIT;
            end else begin
                state_d = S_CMD;
            end
        end
    end

    // State and output registers; reset abandons any sequence in progress.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            step_q       <= STEP_SEL;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            ap_q         <= 8'h0;
            sel_q        <= 8'h0;
            sel_v_q      <= 1'b0;
            csw_q        <= 2'd0;
            csw_v_q      <= 1'b0;
            tar_q        <= 32'h0;
            tar_v_q      <= 1'b0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            rsp_stat_q   <= 3'b000;
            cmd_wrdata_q <= 36'h0;
            cmd_wren_q   <= 1'b0;
            resp_rden_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ap_q         <= ap_d;
            sel_q        <= sel_d;
            sel_v_q      <= sel_v_d;
            csw_q        <= csw_d;
            csw_v_q      <= csw_v_d;
            tar_q        <= tar_d;
            tar_v_q      <= tar_v_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_stat_q   <= rsp_stat_d;
            cmd_wrdata_q <= cmd_wrdata_d;
            cmd_wren_q   <= cmd_wren_d;
            resp_rden_q  <= resp_rden_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign rsp_stat_o   = rsp_stat_q;
    assign cmd_wrdata_o = cmd_wrdata_q;
    assign cmd_wren_o   = cmd_wren_q;
    assign resp_rden_o  = resp_rden_q;

endmodule

// File: tb/tb_swd_memap_seq.sv
// tb_swd_memap_seq
//   Bench for swd_memap_seq. A small SWD engine stand-in answers commands
//   through a response queue; a cache model written from the MEM-AP rules
//   predicts the command list and the reply of every request.
module tb_swd_memap_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  apSel = 8'h0;
    logic        invalidate = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWrite = 1'b0;
    logic [1:0]  reqSize = 2'd0;
    logic [31:0] reqAddr = 32'h0;
    logic [31:0] reqWdata = 32'h0;
    logic        rspValid;
    logic        rspReady = 1'b0;
    logic [31:0] rspRdata;
    logic [2:0]  rspStat;
    logic [35:0] cmdWrdata;
    logic        cmdWren;
    logic        cmdWrfull = 1'b0;
    logic [34:0] respRddata = 35'h0;
    logic        respRden;
    logic        respRdempty = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    swd_memap_seq dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .ap_sel_i       (apSel),
        .invalidate_i   (invalidate),
        .req_valid_i    (reqValid),
        .req_ready_o    (reqReady),
        .req_write_i    (reqWrite),
        .req_size_i     (reqSize),
        .req_addr_i     (reqAddr),
        .req_wdata_i    (reqWdata),
        .rsp_valid_o    (rspValid),
        .rsp_ready_i    (rspReady),
        .rsp_rdata_o    (rspRdata),
        .rsp_stat_o     (rspStat),
        .cmd_wrdata_o   (cmdWrdata),
        .cmd_wren_o     (cmdWren),
        .cmd_wrfull_i   (cmdWrfull),
        .resp_rddata_i  (respRddata),
        .resp_rden_o    (respRden),
        .resp_rdempty_i (respRdempty)
    );

    // Free-running clock and cycle counter used for latency measurement.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Engine stand-in: every written command is logged and answered with a
    // random data word and OK status, unless it is the step chosen to fail.
    // Steps: 0 SELECT, 1 CSW, 2 TAR, 3 DRW.
    logic [35:0] cmdLog[$];
    logic [34:0] engQ[$];
    int          faultStep = -1;
    logic [2:0]  faultStat = 3'b001;
    logic [31:0] engRdata = 32'h0;
    int          lastRdenCyc = 0;

    always @(negedge clk) begin : engine
        logic [31:0] d;
        logic [2:0]  st;
        int          stp;
        if (reset) begin
            engQ.delete();
        end else begin
            if (cmdWren) begin
                cmdLog.push_back(cmdWrdata);
                case (cmdWrdata[3:1])
                    3'b100:  stp = 0;
                    3'b001:  stp = 1;
                    3'b011:  stp = 2;
                    3'b111:  stp = 3;
                    default: stp = -1;
                endcase
                d  = $urandom;
                st = 3'b100;
                if (stp == faultStep) begin
                    st = faultStat;
                    faultStep = -1;
                end
                if (stp == 3) engRdata = d;
                engQ.push_back({d, st});
            end
            if (respRden && engQ.size() > 0) begin
                respRddata  = engQ.pop_front();
                lastRdenCyc = cyc;
            end
        end
        respRdempty = (engQ.size() == 0);
    end

    // Reference cache model.
    logic        mSelV = 1'b0, mCswV = 1'b0, mTarV = 1'b0;
    logic [7:0]  mSel = 8'h0;
    logic [1:0]  mCsw = 2'd0;
    logic [31:0] mTar = 32'h0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulseInvalidate();
        @(negedge clk);
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        mSelV = 1'b0;
        mCswV = 1'b0;
        mTarV = 1'b0;
    endtask

    // Runs one request end to end and checks commands, reply and timing.
    task automatic applyStimulus(input string tag, input logic wr, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [7:0] ap, input int fStep, input logic [2:0] fStat,
                                 input int fullHold, input int rspHold);
        logic [35:0] expCmds[$];
        int          expSteps[$];
        logic [1:0]  sz;
        logic        failed;
        logic [2:0]  expStat;
        logic [31:0] expRdata;
        logic        accepted;
        logic        gotRsp;
        int          n;

        sz = (size == 2'd3) ? 2'd2 : size;
        if (!mSelV || mSel != ap) begin
            expCmds.push_back({ap, 24'h0, 4'b1000});
            expSteps.push_back(0);
        end
        if (!mCswV || mCsw != sz) begin
            expCmds.push_back({32'h2300_0000 | {30'h0, sz}, 4'b0010});
            expSteps.push_back(1);
        end
        if (!mTarV || mTar != addr) begin
            expCmds.push_back({addr, 4'b0110});
            expSteps.push_back(2);
        end
        expCmds.push_back({(wr ? wdata : 32'h0), 3'b111, ~wr});
        expSteps.push_back(3);

        failed = 1'b0;
        for (int i = 0; i < expSteps.size(); i++) begin
            if (!failed && expSteps[i] == fStep) begin
                failed = 1'b1;
                while (expCmds.size() > i + 1) void'(expCmds.pop_back());
            end
        end

        cmdLog.delete();
        faultStep = fStep;
        faultStat = fStat;
        cmdWrfull = (fullHold > 0);

        @(negedge clk);
        reqValid = 1'b1;
        reqWrite = wr;
        reqSize  = size;
        reqAddr  = addr;
        reqWdata = wdata;
        apSel    = ap;
        accepted = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (reqReady) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput({tag, " accepted"}, accepted, 1);
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;

        if (fullHold > 0) begin
            for (int k = 0; k < fullHold; k++) begin
                if (k > 0) @(negedge clk);
                checkOutput({tag, " wren while full"}, cmdWren, 0);
                checkOutput({tag, " held cmd"}, cmdWrdata, expCmds[0]);
            end
            cmdWrfull = 1'b0;
            @(negedge clk);
            checkOutput({tag, " wren after full drops"}, cmdWren, 1);
            checkOutput({tag, " cmd after full drops"}, cmdWrdata, expCmds[0]);
        end else if (expCmds.size() == 1) begin
            checkOutput({tag, " accept to wren"}, cmdWren, 1);
        end

        gotRsp = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rspValid) begin
                gotRsp = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput({tag, " rsp timeout"}, gotRsp, 1);
        checkOutput({tag, " pop to rsp latency"}, cyc - lastRdenCyc, 2);

        expStat  = failed ? fStat : 3'b100;
        expRdata = (failed || wr) ? 32'h0 : engRdata;
        checkOutput({tag, " rsp stat"}, rspStat, expStat);
        checkOutput({tag, " rsp rdata"}, rspRdata, expRdata);
        checkOutput({tag, " cmd count"}, cmdLog.size(), expCmds.size());
        n = (cmdLog.size() < expCmds.size()) ? cmdLog.size() : expCmds.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s cmd%0d", tag, i), cmdLog[i], expCmds[i]);
        end

        for (int k = 0; k < rspHold; k++) begin
            @(negedge clk);
            checkOutput({tag, " rsp held valid"}, rspValid, 1);
            checkOutput({tag, " rsp held rdata"}, rspRdata, expRdata);
            checkOutput({tag, " req_ready while busy"}, reqReady, 0);
        end

        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        checkOutput({tag, " rsp dropped"}, rspValid, 0);

        if (failed) begin
            mSelV = 1'b0;
            mCswV = 1'b0;
            mTarV = 1'b0;
        end else begin
            foreach (expSteps[i]) begin
                case (expSteps[i])
                    0: begin mSel = ap;   mSelV = 1'b1; end
                    1: begin mCsw = sz;   mCswV = 1'b1; end
                    2: begin mTar = addr; mTarV = 1'b1; end
                    default: ;
                endcase
            end
        end
        faultStep = -1;
    endtask

    // Safety net against a wedged design.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        logic [31:0] addrs[3];
        logic [2:0]  stats[4];
        addrs[0] = 32'h2000_0000;
        addrs[1] = 32'h2000_0104;
        addrs[2] = 32'h1FFF_FFFE;
        stats[0] = 3'b001;
        stats[1] = 3'b010;
        stats[2] = 3'b111;
        stats[3] = 3'b000;

        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", reqReady, 0);
        checkOutput("reset rsp_valid", rspValid, 0);
        checkOutput("reset rsp_rdata", rspRdata, 0);
        checkOutput("reset rsp_stat", rspStat, 0);
        checkOutput("reset cmd_wren", cmdWren, 0);
        checkOutput("reset resp_rden", respRden, 0);
        checkOutput("reset cmd_wrdata", cmdWrdata, 0);
        reset = 1'b0;

        applyStimulus("read cold", 1'b0, 2'd2, 32'h2000_0000, 32'h0, 8'h00, -1, 3'b000, 0, 0);
        applyStimulus("read cached", 1'b0, 2'd2, 32'h2000_0000, 32'h0, 8'h00, -1, 3'b000, 0, 0);
        applyStimulus("write byte", 1'b1, 2'd0, 32'h2000_0003, 32'hAB00_0000, 8'h00, -1, 3'b000, 0, 0);
        applyStimulus("tar fault", 1'b0, 2'd2, 32'h2000_1000, 32'h0, 8'h00, 2, 3'b001, 0, 0);
        applyStimulus("after fault", 1'b0, 2'd2, 32'h2000_1000, 32'h0, 8'h00, -1, 3'b000, 0, 0);
        applyStimulus("full hold", 1'b1, 2'd1, 32'h2000_2002, 32'h1234_0000, 8'h00, -1, 3'b000, 10, 0);
        applyStimulus("rsp hold", 1'b0, 2'd2, 32'h2000_3000, 32'h0, 8'h03, -1, 3'b000, 0, 5);
        pulseInvalidate();
        applyStimulus("after invalidate", 1'b0, 2'd2, 32'h2000_3000, 32'h0, 8'h03, -1, 3'b000, 0, 0);

        for (int r = 0; r < 30; r++) begin
            int fs;
            if ($urandom_range(0, 5) == 0) pulseInvalidate();
            fs = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            applyStimulus($sformatf("rand%0d", r), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), addrs[$urandom_range(0, 2)], $urandom,
                          8'($urandom_range(0, 1)), fs, stats[$urandom_range(0, 3)],
                          ($urandom_range(0, 6) == 0) ? 3 : 0, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
